// File: rtl/mesm6_acc.sv
// mesm6_acc: result writeback stage directly downstream of the ALU.
// Captures alu_r into the accumulator and alu_y into the Y register, either
// immediately (alu_done with the request) or after waiting for alu_done.
// Each capture re-evaluates the omega condition flag. A watchdog aborts a
// wait that never completes and raises a sticky error.
//
// Ports:
//   clk, reset_n         clock (rising edge), async active-low reset
//   wb_req               capture request, sampled only in IDLE
//   wb_acc_en, wb_y_en   write enables for ACC / Y, sampled with wb_req
//   wb_grp[1:0]          omega group: 0 hold, 1 logical, 2 additive, 3 multiplicative
//   alu_r, alu_y [47:0]  ALU result / low-order result
//   alu_done             ALU result valid
//   err_clr              clear sticky timeout error
//   acc, y [47:0]        accumulator / Y register
//   omega                condition flag
//   wb_busy              FSM not in IDLE
//   wb_ack               one-cycle pulse ending each request
//   timeout_err          sticky abort indicator
//
// state | meaning
// IDLE  | waiting for wb_req
// WAIT  | request accepted, waiting for alu_done (watchdog running)
// DONE  | ack cycle, returns to IDLE next edge
module mesm6_acc #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_req,
  input  logic        wb_acc_en,
  input  logic        wb_y_en,
  input  logic [1:0]  wb_grp,
  input  logic [47:0] alu_r,
  input  logic [47:0] alu_y,
  input  logic        alu_done,
  input  logic        err_clr,
  output logic [47:0] acc,
  output logic [47:0] y,
  output logic        omega,
  output logic        wb_busy,
  output logic        wb_ack,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        lat_acc_en, lat_y_en;
  logic [1:0]  lat_grp;
  logic        lat_load;
  logic        capture, abort;
  logic        cap_acc_en, cap_y_en;
  logic [1:0]  cap_grp;
  logic [47:0] acc_val;
  logic        omega_val;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    lat_load   = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    // In WAIT the capture uses the controls latched at request time.
    cap_acc_en = lat_acc_en;
    cap_y_en   = lat_y_en;
    cap_grp    = lat_grp;
    case (state)
      IDLE: begin
        if (wb_req) begin
          if (alu_done) begin
            capture    = 1'b1;
            cap_acc_en = wb_acc_en;
            cap_y_en   = wb_y_en;
            cap_grp    = wb_grp;
            state_nxt  = DONE;
          end else begin
            lat_load  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // alu_done has priority over the watchdog on the same edge.
        if (alu_done) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_val = cap_acc_en ? alu_r : acc;
    case (cap_grp)
      2'd0:    omega_val = omega;
      2'd1:    omega_val = |acc_val;
      2'd2:    omega_val = acc_val[40];
      default: omega_val = acc_val[47];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_acc_en  <= 1'b0;
      lat_y_en    <= 1'b0;
      lat_grp     <= 2'd0;
      acc         <= '0;
      y           <= '0;
      omega       <= 1'b0;
      wb_busy     <= 1'b0;
      wb_ack      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (lat_load) begin
        lat_acc_en <= wb_acc_en;
        lat_y_en   <= wb_y_en;
        lat_grp    <= wb_grp;
      end
      if (capture) begin
        if (cap_acc_en) acc <= alu_r;
        if (cap_y_en)   y   <= alu_y;
        omega <= omega_val;
      end
      // Status outputs are registered copies of the next state.
      wb_busy <= (state_nxt != IDLE);
      wb_ack  <= (state_nxt == DONE);
      if (abort)        timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mesm6_acc.sv
// Testbench for mesm6_acc: directed scenarios plus randomized requests,
// checked by a scoreboard monitor against a transaction-level model.
module tb_mesm6_acc;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_req = 1'b0;
  logic        wb_acc_en = 1'b0;
  logic        wb_y_en = 1'b0;
  logic [1:0]  wb_grp = 2'd0;
  logic [47:0] alu_r = '0;
  logic [47:0] alu_y = '0;
  logic        alu_done = 1'b0;
  logic        err_clr = 1'b0;
  logic [47:0] acc, y;
  logic        omega, wb_busy, wb_ack, timeout_err;

  mesm6_acc #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .wb_req(wb_req), .wb_acc_en(wb_acc_en),
    .wb_y_en(wb_y_en), .wb_grp(wb_grp), .alu_r(alu_r), .alu_y(alu_y),
    .alu_done(alu_done), .err_clr(err_clr), .acc(acc), .y(y), .omega(omega),
    .wb_busy(wb_busy), .wb_ack(wb_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] acc;
    logic [47:0] y;
    logic        omega;
    logic        err;
    int          ack_cyc;
    int          busy;
  } exp_t;

  exp_t sb[$];

  // Architectural model of the visible registers.
  logic [47:0] m_acc = '0;
  logic [47:0] m_y = '0;
  logic        m_omega = 1'b0;
  logic        m_err = 1'b0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  int   busy_run = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    busy_run = (reset_n && wb_busy) ? busy_run + 1 : 0;
    if (!reset_n) begin
      chk("rst_acc", acc, 48'h0);
      chk("rst_y", y, 48'h0);
      chk("rst_omega", 48'(omega), 48'h0);
      chk("rst_busy", 48'(wb_busy), 48'h0);
      chk("rst_ack", 48'(wb_ack), 48'h0);
      chk("rst_err", 48'(timeout_err), 48'h0);
    end else begin
      if (sb.size() > 0 && cyc > sb[0].ack_cyc) begin
        chk("missing_ack", 48'(cyc), 48'(sb[0].ack_cyc));
        void'(sb.pop_front());
      end
      if (wb_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 48'(wb_ack), 48'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_cycle", 48'(cyc), 48'(mon_e.ack_cyc));
          chk("ack_acc", acc, mon_e.acc);
          chk("ack_y", y, mon_e.y);
          chk("ack_omega", 48'(omega), 48'(mon_e.omega));
          chk("ack_err", 48'(timeout_err), 48'(mon_e.err));
          chk("busy_len", 48'(busy_run), 48'(mon_e.busy));
        end
      end else if (!wb_busy && sb.size() == 0) begin
        chk("idle_acc", acc, m_acc);
        chk("idle_y", y, m_y);
        chk("idle_omega", 48'(omega), 48'(m_omega));
        chk("idle_err", 48'(timeout_err), 48'(m_err));
      end
    end
  end

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage();
    wb_req    = 1'($urandom_range(0, 1));
    wb_acc_en = 1'($urandom_range(0, 1));
    wb_y_en   = 1'($urandom_range(0, 1));
    wb_grp    = 2'($urandom_range(0, 3));
    alu_r     = rnd48();
    alu_y     = rnd48();
  endtask

  // n = 0: done with request; n > 0: done n cycles later; n < 0: never (abort).
  task automatic run_req(input logic ae, input logic ye, input logic [1:0] g,
                         input logic [47:0] r, input logic [47:0] yv,
                         input int n, input logic clr);
    exp_t        e;
    logic [47:0] v;
    int          lat;
    int          guard;
    lat = (n < 0) ? TIMEOUT : n;
    if (n < 0) begin
      m_err = 1'b1;
    end else begin
      v = ae ? r : m_acc;
      m_acc = v;
      if (ye) m_y = yv;
      case (g)
        2'd1: m_omega = (v != 48'h0);
        2'd2: m_omega = v[40];
        2'd3: m_omega = v[47];
        default: ;
      endcase
      if (clr) m_err = 1'b0;
    end
    e.acc = m_acc; e.y = m_y; e.omega = m_omega; e.err = m_err;
    e.ack_cyc = cyc + 1 + lat;
    e.busy = lat + 1;
    sb.push_back(e);

    err_clr   = clr;
    wb_req    = 1'b1;
    wb_acc_en = ae;
    wb_y_en   = ye;
    wb_grp    = g;
    alu_done  = (n == 0);
    alu_r     = (n == 0) ? r : rnd48();
    alu_y     = (n == 0) ? yv : rnd48();
    step();
    if (n > 0) begin
      for (int i = 1; i < n; i++) begin
        garbage();
        step();
      end
      garbage();
      alu_r = r;
      alu_y = yv;
      alu_done = 1'b1;
      step();
    end
    alu_done = 1'b0;
    guard = 0;
    while (wb_busy) begin
      if (guard >= 300) begin
        $display("FAIL busy_stuck: wb_busy still 1 after %0d cycles", guard);
        $fatal(1);
      end
      garbage();
      step();
      guard++;
    end
    wb_req = 1'b0;
    if (clr) begin
      m_err = 1'b0;
      err_clr = 1'b0;
    end
  endtask

  initial begin
    int sel;
    int n;
    logic [47:0] r;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Zero-wait capture
    run_req(1'b1, 1'b1, 2'd1, 48'h000000000005, 48'hFFFF00000000, 0, 1'b0);
    // Multicycle with mantissa sign set, additive group
    run_req(1'b1, 1'b0, 2'd2, 48'h0100000000A0, 48'h0, 3, 1'b0);
    // Omega groups
    run_req(1'b1, 1'b0, 2'd3, 48'h7FFFFFFFFFFF, 48'h0, 1, 1'b0);
    run_req(1'b1, 1'b0, 2'd0, 48'h800000000000, 48'h0, 0, 1'b0);
    run_req(1'b1, 1'b0, 2'd0, 48'h000000000000, 48'h0, 2, 1'b0);
    run_req(1'b0, 1'b0, 2'd1, 48'hFFFFFFFFFFFF, 48'h0, 0, 1'b0);
    run_req(1'b0, 1'b1, 2'd1, 48'h0, 48'h123, 1, 1'b0);
    // Timeout: registers unchanged, error sticky until cleared
    run_req(1'b1, 1'b1, 2'd1, 48'hABCDEF, 48'h55, -1, 1'b0);
    repeat (3) step();
    err_clr = 1'b1;
    step();
    m_err = 1'b0;
    err_clr = 1'b0;
    step();
    // Clear coincident with a new abort: set wins
    run_req(1'b1, 1'b0, 2'd3, 48'h1, 48'h0, -1, 1'b1);
    step();
    // Stale done in IDLE must not be captured later
    alu_done = 1'b1;
    alu_r = 48'hDEADBEEF0000;
    step();
    alu_done = 1'b0;
    run_req(1'b1, 1'b1, 2'd3, 48'h800000000001, 48'h77, 2, 1'b0);
    // Last legal done delay
    run_req(1'b1, 1'b0, 2'd2, 48'h000000000042, 48'h0, TIMEOUT - 1, 1'b0);

    // Randomized requests
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      n = (sel == 0) ? -1 : $urandom_range(0, TIMEOUT - 1);
      r = ($urandom_range(0, 4) == 0) ? 48'h0 : rnd48();
      run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), r, rnd48(), n,
              1'($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 2) == 0) step();
    end

    // Reset mid-WAIT with a known accumulator value
    run_req(1'b1, 1'b0, 2'd0, 48'h123456789ABC, 48'h0, 0, 1'b0);
    step();
    wb_req = 1'b1;
    alu_done = 1'b0;
    step();
    wb_req = 1'b0;
    step();
    reset_n = 1'b0;
    m_acc = '0; m_y = '0; m_omega = 1'b0; m_err = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    repeat (6) step();
    run_req(1'b1, 1'b1, 2'd1, 48'h0, 48'h9, 1, 1'b0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesm6_acc.md
# mesm6_acc

Result writeback stage directly downstream of the ALU. Captures the ALU result (`alu_r`) into the accumulator and the low-order result (`alu_y`) into the Y register. Single-cycle operations complete immediately; multicycle operations are waited on through the ALU `done` signal. On each capture the block updates the omega condition flag. A watchdog aborts a wait that never completes.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before abort; legal range 2..255.

- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `wb_req` in 1: request a capture; sampled only in IDLE.
- `wb_acc_en` in 1: write `alu_r` to ACC; sampled with `wb_req`.
- `wb_y_en` in 1: write `alu_y` to Y; sampled with `wb_req`.
- `wb_grp` in 2: omega group, sampled with `wb_req`:
  - 0: hold
  - 1: logical
  - 2: additive
  - 3: multiplicative
- `alu_r` in 48: ALU result.
- `alu_y` in 48: ALU least-significant result bits.
- `alu_done` in 1: ALU result valid.
- `err_clr` in 1: clear sticky timeout error.
- `acc` out 48: accumulator; feeds ALU `alu_a`.
- `y` out 48: Y register.
- `omega` out 1: condition flag.
- `wb_busy` out 1: high whenever the FSM is not in IDLE.
- `wb_ack` out 1: one-cycle pulse ending each request.
- `timeout_err` out 1: sticky abort indicator.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, `wb_req`=1, `alu_done`=1:
  - Capture at this edge.
  - Go to DONE.
- IDLE, `wb_req`=1, `alu_done`=0:
  - Latch `wb_acc_en`, `wb_y_en`, `wb_grp`.
  - Clear the wait counter.
  - Go to WAIT.
- IDLE, `wb_req`=0: stay.
- WAIT:
  - `alu_done`=1: capture using the latched controls, go to DONE.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT-1 with `alu_done` still 0: set `timeout_err`, go to DONE, no capture.
- DONE: `wb_ack`=1 for this cycle only, then go to IDLE.
- `wb_req` is ignored in WAIT and DONE. The requester must hold off until `wb_busy`=0.
- Capture:
  - ACC ← `alu_r` if acc_en.
  - Y ← `alu_y` if y_en.
  - Enables with both bits 0 still update omega and ack.
- Omega evaluation. Value v = new ACC if acc_en, else current ACC.
  - grp 0: omega unchanged.
  - grp 1: omega = (v != 0).
  - grp 2: omega = v[40] (mantissa sign).
  - grp 3: omega = v[47] (exponent MSB).
- Aborted (timeout) requests leave ACC, Y and omega unchanged.
- `timeout_err`:
  - Set on abort.
  - Cleared by `err_clr`.
  - If set and clear occur in the same cycle, set wins.
- All arithmetic is plain 48-bit register transfer; no sign extension or truncation.

## Timing
- Reset values: state IDLE, counter 0, `acc`=0, `y`=0, `omega`=0, `wb_busy`=0, `wb_ack`=0, `timeout_err`=0.
- All outputs are registered.
- `acc`, `y`, `omega` change on the capture edge and are visible the following cycle.
- Latency when `alu_done` is present with the request:
  - Capture at edge k.
  - `wb_busy`=1 and `wb_ack`=1 during cycle k+1.
  - IDLE again at edge k+2.
  - Next `wb_req` accepted at edge k+2.
- Latency with `alu_done` arriving n cycles after the request (1 ≤ n ≤ TIMEOUT-1): capture at edge k+n, `wb_ack` in cycle k+n+1.
- Abort: `wb_ack` and `timeout_err` are first seen together, TIMEOUT+1 cycles after the request edge.
- `alu_done` in IDLE without `wb_req` is ignored. A stale `alu_done` is never captured later.
- Reset mid-WAIT or mid-DONE:
  - Immediate return to IDLE.
  - No ack.
  - All registers return to reset values.

## Test plan
- Reset:
  - Apply reset with `acc` = 0x123456789ABC and the FSM in WAIT.
  - Required: all outputs 0 and IDLE immediately; no `wb_ack` after release.
- Zero-wait capture:
  - `wb_req`, acc_en=1, y_en=1, grp=1, `alu_done`=1, `alu_r`=0x000000000005, `alu_y`=0xFFFF00000000.
  - Required next cycle: `acc`=5, `y`=0xFFFF00000000, `omega`=1, `wb_ack`=1 for exactly one cycle.
- Multicycle:
  - Request with acc_en=1, grp=2; raise `alu_done` 3 cycles later with `alu_r` bit 40 set.
  - Required: `wb_busy` high for 4 cycles, `acc` updated, `omega`=1, `wb_ack` at cycle 4.
  - Requests issued while busy are ignored.
- Omega groups:
  - Sequence grp=3 with v[47]=0 → `omega`=0.
  - grp=0 → `omega` holds 0.
  - grp=1 with acc_en=0, `acc`=0 → `omega`=0.
- Timeout:
  - TIMEOUT=4, `alu_done` held 0.
  - Required: `wb_ack` and `timeout_err` in cycle 5; ACC/Y/omega unchanged; `timeout_err` stays 1 until `err_clr`.
  - Simultaneous `err_clr` and new abort leaves `timeout_err`=1.
- Stale done:
  - Pulse `alu_done` in IDLE without `wb_req`, then issue `wb_req` with `alu_done`=0.
  - Required: FSM enters WAIT and no capture occurs until a fresh `alu_done`.
